// File: rtl/daisy_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : daisy_chain_pkg
//  Description : Shared types and default settings for the daisy-chain master
//                and the slave blocks of the chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package daisy_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RECV   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int c_n_slaves_default = 2;
    localparam int c_clk_div_default  = 4;
    localparam int c_timeout_default  = 64;

    // Counter width covering 8*n_slaves bits and the 8-bit timeout range,
    // so the shared frame counter can never wrap.
    function automatic int cnt_width(input int n_slaves);
        int w;
        w = 1;
        while ((1 << w) <= (8 * n_slaves)) w = w + 1;
        if (w < 8) w = 8;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/daisy_chain_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : daisy_chain_sclk_gen
//  Description : Serial clock divider. While en is high sclk toggles every
//                CLK_DIV clk cycles; rise_tick/fall_tick flag the clk cycle
//                whose closing edge makes sclk rise/fall. Held low and
//                restarted from zero whenever en is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module daisy_chain_sclk_gen
    import daisy_chain_pkg::*;
#(
    parameter int CLK_DIV = c_clk_div_default
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

    logic [7:0] r_div_cnt;
    logic       r_sclk;
    logic       w_half;

    assign w_half    = en && (r_div_cnt == c_div_last);
    assign rise_tick = w_half && !r_sclk;
    assign fall_tick = w_half && r_sclk;
    assign sclk      = r_sclk;

    // Half-period counter and sclk toggle; disabled means low and restarted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= 8'd0;
            r_sclk    <= 1'b0;
        end else if (!en) begin
            r_div_cnt <= 8'd0;
            r_sclk    <= 1'b0;
        end else if (w_half) begin
            r_div_cnt <= 8'd0;
            r_sclk    <= ~r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/daisy_chain_master.sv
`default_nettype none
// ============================================================================
//  Module      : daisy_chain_master
//  Description : Master for a chain of 8-bit shift-register slaves. Shifts a
//                frame out LSB-first (byte 0 first), waits for the chain to
//                report readiness, then reads back one byte from the last
//                slave. Aborts with a timeout pulse if readiness never comes.
//  Revision    : 1.0 - initial release
// ============================================================================
module daisy_chain_master
    import daisy_chain_pkg::*;
#(
    parameter int N_SLAVES = c_n_slaves_default,
    parameter int CLK_DIV  = c_clk_div_default,
    parameter int TIMEOUT  = c_timeout_default
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  newd,
    input  logic [8*N_SLAVES-1:0] din,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso,
    input  logic                  chain_ready,
    output logic [7:0]            dout,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam int c_bits  = 8 * N_SLAVES;
    localparam int c_cnt_w = cnt_width(N_SLAVES);

    localparam logic [c_cnt_w-1:0] c_bits_cnt  = c_cnt_w'(c_bits);
    localparam logic [c_cnt_w-1:0] c_tmo_cnt   = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_recv_last = c_cnt_w'(7);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_en;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_count;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bits-1:0]    r_tx_sr;
    logic [7:0]           r_rx_sr;
    logic [7:0]           r_dout;
    logic                 r_cs;
    logic                 r_mosi;
    logic                 r_done;
    logic                 r_timeout;
    logic                 r_to_flag;

    // sclk only runs in the three shifting states.
    assign w_en = (r_state == ST_SEND) || (r_state == ST_WAIT) || (r_state == ST_RECV);

    daisy_chain_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (w_en),
        .sclk      (sclk),
        .rise_tick (w_rise),
        .fall_tick (w_fall)
    );

    assign cs      = r_cs;
    assign mosi    = r_mosi;
    assign dout    = r_dout;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign busy    = (r_state != ST_IDLE);

    // Next-state and counter-advance decode. Leaving SEND/WAIT/RECV always
    // happens on a falling tick (except WAIT->RECV) so sclk ends low.
    always_comb begin
        w_state_nxt = r_state;
        w_count     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (newd) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_count = w_rise;
                if (w_fall && (r_cnt == c_bits_cnt)) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_count = w_rise;
                if (w_rise && chain_ready) w_state_nxt = ST_RECV;
                else if (w_fall && (r_cnt == c_tmo_cnt)) w_state_nxt = ST_FINISH;
            end
            ST_RECV: begin
                w_count = w_fall;
                if (w_fall && (r_cnt == c_recv_last)) w_state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Frame datapath: edge counter, shift registers, cs/mosi and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= 8'd0;
            r_dout    <= 8'd0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_to_flag <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (w_count)           r_cnt <= r_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (newd) begin
                        r_tx_sr   <= {1'b0, din[c_bits-1:1]};
                        r_mosi    <= din[0];
                        r_cs      <= 1'b0;
                        r_to_flag <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_fall) begin
                        if (r_cnt == c_bits_cnt) begin
                            r_mosi <= 1'b0;
                        end else begin
                            r_mosi  <= r_tx_sr[0];
                            r_tx_sr <= {1'b0, r_tx_sr[c_bits-1:1]};
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_state_nxt == ST_FINISH) r_to_flag <= 1'b1;
                end
                ST_RECV: begin
                    if (w_fall) r_rx_sr <= {miso, r_rx_sr[7:1]};
                end
                ST_FINISH: begin
                    r_cs <= 1'b1;
                    if (r_to_flag) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                        r_dout <= r_rx_sr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_daisy_chain_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_daisy_chain_master
//  Description : Bench for daisy_chain_master. Two instances (fast 2-slave,
//                slow 1-slave) driven by a behavioural chain model that
//                captures mosi on sclk rises, raises chain_ready at a chosen
//                wait edge and returns a byte on miso.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_daisy_chain_master;

    localparam int c_div_a = 2;
    localparam int c_tmo_a = 8;
    localparam int c_div_b = 255;
    localparam int c_tmo_b = 4;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [1:0]  newd_v = 2'b00;
    logic [1:0]  rdy_v  = 2'b00;
    logic [1:0]  miso_v = 2'b00;
    logic [15:0] din_a  = 16'h0;
    logic [7:0]  din_b  = 8'h0;
    logic [1:0]  sclk_v, cs_v, mosi_v, busy_v, done_v, tmo_v;
    logic [7:0]  dout_a, dout_b;

    // chain model state
    int          rise_cnt[2];
    int          run_len[2];
    int          hmin[2];
    int          hmax[2];
    int          done_cnt[2];
    int          tmo_cnt[2];
    logic [15:0] cap[2];
    logic [1:0]  prev_sclk = 2'b00;
    logic [1:0]  prev_cs   = 2'b11;
    int          cfg_ready_at[2];
    logic [7:0]  cfg_ret[2];
    logic [7:0]  exp_dout[2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    daisy_chain_master #(.N_SLAVES(2), .CLK_DIV(c_div_a), .TIMEOUT(c_tmo_a)) u_dut_a (
        .clk(clk), .rst(rst), .newd(newd_v[0]), .din(din_a), .sclk(sclk_v[0]),
        .cs(cs_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]), .chain_ready(rdy_v[0]),
        .dout(dout_a), .busy(busy_v[0]), .done(done_v[0]), .timeout(tmo_v[0])
    );

    daisy_chain_master #(.N_SLAVES(1), .CLK_DIV(c_div_b), .TIMEOUT(c_tmo_b)) u_dut_b (
        .clk(clk), .rst(rst), .newd(newd_v[1]), .din(din_b), .sclk(sclk_v[1]),
        .cs(cs_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]), .chain_ready(rdy_v[1]),
        .dout(dout_b), .busy(busy_v[1]), .done(done_v[1]), .timeout(tmo_v[1])
    );

    function automatic int nbits_of(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic int tmo_of(input int k);
        return (k == 0) ? c_tmo_a : c_tmo_b;
    endfunction

    function automatic int div_of(input int k);
        return (k == 0) ? c_div_a : c_div_b;
    endfunction

    function automatic logic [7:0] dout_of(input int k);
        return (k == 0) ? dout_a : dout_b;
    endfunction

    // Behavioural chain: sampled mid-cycle, away from the active clk edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_v[k]) done_cnt[k] = done_cnt[k] + 1;
            if (tmo_v[k])  tmo_cnt[k]  = tmo_cnt[k] + 1;
            if (!cs_v[k] && prev_cs[k]) begin
                rise_cnt[k] = 0; cap[k] = 16'h0; run_len[k] = 0;
                hmin[k] = 1000000; hmax[k] = 0; done_cnt[k] = 0; tmo_cnt[k] = 0;
            end
            if (cs_v[k]) begin
                run_len[k] = 0; rdy_v[k] = 1'b0; miso_v[k] = 1'b0;
            end else begin
                if (sclk_v[k] != prev_sclk[k]) begin
                    if (run_len[k] < hmin[k]) hmin[k] = run_len[k];
                    if (run_len[k] > hmax[k]) hmax[k] = run_len[k];
                    run_len[k] = 1;
                end else begin
                    run_len[k] = run_len[k] + 1;
                end
                if (sclk_v[k] && !prev_sclk[k]) begin
                    rise_cnt[k] = rise_cnt[k] + 1;
                    if (rise_cnt[k] <= nbits_of(k)) cap[k][rise_cnt[k]-1] = mosi_v[k];
                    if (cfg_ready_at[k] != 0 && rise_cnt[k] == cfg_ready_at[k] - 1) rdy_v[k] = 1'b1;
                    if (cfg_ready_at[k] != 0 && rise_cnt[k] >= cfg_ready_at[k] &&
                        rise_cnt[k] - cfg_ready_at[k] < 8)
                        miso_v[k] = cfg_ret[k][rise_cnt[k] - cfg_ready_at[k]];
                end
            end
            prev_sclk[k] = sclk_v[k];
            prev_cs[k]   = cs_v[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int k, input string tag);
        chk({tag, ".sclk"},    32'(sclk_v[k]), 32'd0);
        chk({tag, ".cs"},      32'(cs_v[k]),   32'd1);
        chk({tag, ".mosi"},    32'(mosi_v[k]), 32'd0);
        chk({tag, ".busy"},    32'(busy_v[k]), 32'd0);
        chk({tag, ".done"},    32'(done_v[k]), 32'd0);
        chk({tag, ".timeout"}, 32'(tmo_v[k]),  32'd0);
        chk({tag, ".dout"},    32'(dout_of(k)), 32'd0);
    endtask

    // One frame on instance k. rdy = wait edge at which the chain reports
    // ready (0 = never); success iff 1 <= rdy <= TIMEOUT.
    task automatic run_frame(input int k, input logic [15:0] d, input logic [7:0] ret,
                             input int rdy, input bit extra_newd, input bit rst_in_recv,
                             input string tag);
        int  nb;
        int  to;
        int  dv;
        int  budget;
        bit  ok_end;
        bit  success;
        logic [15:0] exp_cap;
        nb      = nbits_of(k);
        to      = tmo_of(k);
        dv      = div_of(k);
        success = (rdy >= 1) && (rdy <= to);
        exp_cap = (k == 0) ? d : {8'h00, d[7:0]};
        cfg_ret[k]      = ret;
        cfg_ready_at[k] = (rdy > 0) ? nb + rdy : 0;

        @(negedge clk);
        if (k == 0) din_a = d; else din_b = d[7:0];
        newd_v[k] = 1'b1;
        @(negedge clk);
        newd_v[k] = 1'b0;
        chk({tag, ".start_cs"},   32'(cs_v[k]),   32'd0);
        chk({tag, ".start_busy"}, 32'(busy_v[k]), 32'd1);
        chk({tag, ".start_mosi"}, 32'(mosi_v[k]), 32'(d[0]));

        if (extra_newd) begin
            repeat (5 * dv) @(negedge clk);
            if (k == 0) din_a = ~d; else din_b = ~d[7:0];
            newd_v[k] = 1'b1;
            @(negedge clk);
            newd_v[k] = 1'b0;
        end

        budget = (nb + to + 12) * 2 * dv + 20;
        ok_end = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rst_in_recv && rise_cnt[k] >= nb + rdy + 2) begin ok_end = 1'b1; break; end
            if (!busy_v[k]) begin ok_end = 1'b1; break; end
        end
        chk({tag, ".reached_end"}, 32'(ok_end), 32'd1);

        if (rst_in_recv) begin
            rst = 1'b1;
            #1;
            exp_dout[0] = 8'h00;
            exp_dout[1] = 8'h00;
            chk_reset_outputs(k, {tag, ".rst"});
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            chk({tag, ".no_done"},    32'(done_cnt[k]), 32'd0);
            chk({tag, ".no_timeout"}, 32'(tmo_cnt[k]),  32'd0);
        end else begin
            repeat (2) @(negedge clk);
            if (success) exp_dout[k] = ret;
            chk({tag, ".done_pulses"}, 32'(done_cnt[k]), success ? 32'd1 : 32'd0);
            chk({tag, ".tmo_pulses"},  32'(tmo_cnt[k]),  success ? 32'd0 : 32'd1);
            chk({tag, ".cs_after"},    32'(cs_v[k]),   32'd1);
            chk({tag, ".sclk_after"},  32'(sclk_v[k]), 32'd0);
            chk({tag, ".mosi_after"},  32'(mosi_v[k]), 32'd0);
            chk({tag, ".dout"},        32'(dout_of(k)), 32'(exp_dout[k]));
            chk({tag, ".mosi_bits"},   32'(cap[k]), 32'(exp_cap));
            chk({tag, ".rise_edges"},  32'(rise_cnt[k]),
                success ? 32'(nb + rdy + 7) : 32'(nb + to));
            chk({tag, ".half_min"},    32'(hmin[k]), 32'(dv));
            chk({tag, ".half_max"},    32'(hmax[k]), 32'(dv));
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  rr;
        int          rk;
        cfg_ready_at[0] = 0; cfg_ready_at[1] = 0;
        cfg_ret[0] = 8'h00;  cfg_ret[1] = 8'h00;
        exp_dout[0] = 8'h00; exp_dout[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            rise_cnt[k] = 0; run_len[k] = 0; hmin[k] = 0; hmax[k] = 0;
            done_cnt[k] = 0; tmo_cnt[k] = 0; cap[k] = 16'h0;
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs(0, "reset_a");
        chk_reset_outputs(1, "reset_b");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(0, 16'hA55A, 8'h3C, 3, 1'b0, 1'b0, "basic");
        run_frame(0, 16'hA55A, 8'h77, 0, 1'b0, 1'b0, "timeout");
        run_frame(0, 16'h1234, 8'hC5, 2, 1'b1, 1'b0, "renewd");
        run_frame(0, 16'hBEEF, 8'h99, 4, 1'b0, 1'b1, "rst_recv");
        run_frame(0, 16'h0001, 8'h5A, 1, 1'b0, 1'b0, "after_rst");
        run_frame(0, 16'h00F0, 8'h81, c_tmo_a, 1'b0, 1'b0, "coincide_a");

        for (int i = 0; i < 10; i++) begin
            rd = 16'($urandom);
            rr = 8'($urandom);
            rk = int'($urandom_range(0, 10));
            run_frame(0, rd, rr, rk, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        run_frame(1, 16'h00FF, 8'hA6, c_tmo_b, 1'b0, 1'b0, "slow_coincide");
        rd = 16'($urandom);
        run_frame(1, rd, 8'h3B, 0, 1'b0, 1'b0, "slow_timeout");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/daisy_chain_master.md
DAISY_CHAIN_MASTER -- requirements
Module: daisy_chain_master

Interface
REQ-001 SHALL provide parameter N_SLAVES, default 2, number of 8-bit slaves in the chain (1..8).
REQ-002 SHALL provide parameter CLK_DIV, default 4, sclk half-period in clk cycles (2..255).
REQ-003 SHALL provide parameter TIMEOUT, default 64, maximum sclk periods in WAIT before abort (1..255).
REQ-004 SHALL provide port clk  input  1  system clock; all logic on posedge clk.
REQ-005 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port newd  input  1  start request, sampled only in IDLE.
REQ-007 SHALL provide port din  input  8*N_SLAVES  frame payload; byte 0 (bits 7:0) goes to the farthest slave and is sent first.
REQ-008 SHALL provide port sclk  output  1  serial clock to the chain, idle low.
REQ-009 SHALL provide port cs  output  1  chip select, active-low, idle high.
REQ-010 SHALL provide port mosi  output  1  serial data to the first slave's sdi.
REQ-011 SHALL provide port miso  input  1  serial data from the last slave's sdo.
REQ-012 SHALL provide port chain_ready  input  1  done flag from the chain's last-but-one slave: the last slave has begun its send phase.
REQ-013 SHALL provide port dout  output  8  byte returned by the last slave.
REQ-014 SHALL provide port busy  output  1  high from newd acceptance until return to IDLE.
REQ-015 SHALL provide port done  output  1  one-clk pulse on successful completion.
REQ-016 SHALL provide port timeout  output  1  one-clk pulse on WAIT abort.

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT, RECV, FINISH.
REQ-018 In IDLE with newd=1, SHALL latch din, drive cs=0 and mosi=din[0] on the next clk, set busy=1 and enter SEND; newd while busy SHALL be ignored.
REQ-019 sclk SHALL toggle every CLK_DIV clk cycles while state is SEND, WAIT or RECV, and SHALL be held low otherwise.
REQ-020 In SEND, mosi SHALL change only on sclk falling edges, LSB-first, byte 0 first, so slaves sample stable data on rising edges.
REQ-021 SEND SHALL last exactly 8*N_SLAVES sclk rising edges, then enter WAIT with mosi=0.
REQ-022 In WAIT, when chain_ready=1 is sampled at an sclk rising edge, SHALL enter RECV; after TIMEOUT rising edges without it, SHALL enter FINISH with timeout flagged.
REQ-023 In RECV, SHALL sample miso on each of the next 8 sclk falling edges into dout LSB-first, then enter FINISH.
REQ-024 FINISH SHALL hold sclk low, raise cs one clk later, and pulse done (or timeout) for exactly one clk, then return to IDLE with busy=0.
REQ-025 dout SHALL update only on successful completion and SHALL retain its previous value on timeout.
REQ-026 The bit counter SHALL be wide enough for 8*N_SLAVES and SHALL never wrap within a frame; the sclk divider SHALL restart at 0 on every state entry from IDLE.
REQ-027 If chain_ready and the TIMEOUT limit occur on the same rising edge, chain_ready SHALL win.

Reset
REQ-028 rst=1 SHALL immediately force IDLE: sclk=0, cs=1, mosi=0, dout=0, busy=0, done=0, timeout=0, and clear all counters.
REQ-029 rst asserted mid-frame SHALL abort without a done or timeout pulse; the first newd after release SHALL start a clean frame.

Structure
REQ-030 The state enum and the default values of N_SLAVES, CLK_DIV and TIMEOUT SHALL live in shared package daisy_chain_pkg, also used by the slave blocks.
REQ-031 The sclk divider and rise/fall tick generation SHALL be the sub-module daisy_chain_sclk_gen, with inputs clk, rst and en, and outputs sclk, rise_tick and fall_tick.

Verification
REQ-032 N_SLAVES=2, CLK_DIV=2, din=16'hA55A, chain model returns 8'h3C -> mosi carries 5A then A5 LSB-first, dout=8'h3C, one done pulse, cs high afterwards.
REQ-033 Same frame with chain_ready never asserted, TIMEOUT=8 -> timeout pulse after 16+8 sclk rising edges, done=0, dout unchanged, cs=1.
REQ-034 newd pulsed again in the middle of SEND -> ignored; exactly 16 transmit rising edges; single done.
REQ-035 rst asserted during RECV -> all outputs at reset values within the same cycle, no done; a following frame with din=16'h0001 completes correctly.
REQ-036 CLK_DIV=255, N_SLAVES=1, din=8'hFF -> sclk half-period exactly 255 clk cycles, 8 transmit edges, and chain_ready coinciding with the timeout edge enters RECV.
